// File: rtl/ctrl_pipe_pkg.sv
// rtl/ctrl_pipe_pkg.sv - widths, encodings and stage types for ctrl_pipe
// CTRL_PIPE_FWD_EN adds the rs fields the forwarding logic needs to the ID/EX stage.
package ctrl_pipe_pkg;

  localparam int EX_W  = 5;
  localparam int M_W   = 3;
  localparam int WB_W  = 3;
  localparam int REG_W = 5;
  localparam int MTR_W = 2;
  localparam int FWD_W = 2;

  localparam logic [MTR_W-1:0] MEM_TO_REG_ALU = 2'b00;
  localparam logic [MTR_W-1:0] MEM_TO_REG_IMM = 2'b01;
  localparam logic [MTR_W-1:0] MEM_TO_REG_PC4 = 2'b10;
  localparam logic [MTR_W-1:0] MEM_TO_REG_MEM = 2'b11;

  localparam logic [FWD_W-1:0] FWD_RF  = 2'b00;
  localparam logic [FWD_W-1:0] FWD_MEM = 2'b01;
  localparam logic [FWD_W-1:0] FWD_WB  = 2'b10;

  localparam int EX_ALU_SRC_B  = 4;
  localparam int M_BRANCH      = 2;
  localparam int M_B_TYPE      = 1;
  localparam int M_MEM_WRITE   = 0;
  localparam int WB_REG_WRITE  = 2;
  localparam int WB_MTR_HI     = 1;
  localparam int WB_MTR_LO     = 0;

  typedef struct packed {
    logic             valid;
    logic [EX_W-1:0]  ex;
    logic [M_W-1:0]   m;
    logic [WB_W-1:0]  wb;
    logic [REG_W-1:0] rd;
`ifdef CTRL_PIPE_FWD_EN
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
`endif
  } idex_t;

  // Later stages keep only the fields something downstream still reads.
  typedef struct packed {
    logic             valid;
    logic             mem_write;
    logic [WB_W-1:0]  wb;
    logic [REG_W-1:0] rd;
  } exmem_t;

  typedef struct packed {
    logic             valid;
    logic [WB_W-1:0]  wb;
    logic [REG_W-1:0] rd;
  } memwb_t;

  function automatic logic [MTR_W-1:0] mtr_of(input logic [WB_W-1:0] wb);
    return wb[WB_MTR_HI:WB_MTR_LO];
  endfunction

endpackage

// File: rtl/ctrl_pipe_if.sv
// rtl/ctrl_pipe_if.sv - decode-side inputs and pipeline control outputs of ctrl_pipe
// master drives the ID stage; slave is ctrl_pipe.
interface ctrl_pipe_if;
  import ctrl_pipe_pkg::*;

  logic             hold;
  logic             id_valid;
  logic [EX_W-1:0]  id_ex;
  logic [M_W-1:0]   id_m;
  logic [WB_W-1:0]  id_wb;
  logic [REG_W-1:0] id_rd;
  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic             ex_zero;

  logic [EX_W-1:0]  ex_ctrl;
  logic             ex_valid;
  logic             mem_write;
  logic [MTR_W-1:0] mem_to_reg_m;
  logic [REG_W-1:0] mem_rd;
  logic             wb_reg_write;
  logic [MTR_W-1:0] wb_mem_to_reg;
  logic [REG_W-1:0] wb_rd;
  logic             stall;
  logic             flush;
  logic [FWD_W-1:0] forward_a;
  logic [FWD_W-1:0] forward_b;

  modport master (
    output hold, id_valid, id_ex, id_m, id_wb, id_rd, id_rs1, id_rs2, ex_zero,
    input  ex_ctrl, ex_valid, mem_write, mem_to_reg_m, mem_rd,
           wb_reg_write, wb_mem_to_reg, wb_rd, stall, flush, forward_a, forward_b
  );

  modport slave (
    input  hold, id_valid, id_ex, id_m, id_wb, id_rd, id_rs1, id_rs2, ex_zero,
    output ex_ctrl, ex_valid, mem_write, mem_to_reg_m, mem_rd,
           wb_reg_write, wb_mem_to_reg, wb_rd, stall, flush, forward_a, forward_b
  );

endinterface

// File: rtl/ctrl_pipe_hazard_unit.sv
// rtl/ctrl_pipe_hazard_unit.sv - load-use/RAW stall and ALU operand forwarding selects
// CTRL_PIPE_FWD_EN selects forwarding; otherwise every RAW on EX/MEM producers stalls.
module hazard_unit
  import ctrl_pipe_pkg::*;
(
  input  logic             hold_i,
  input  logic             redirect_i,
  input  logic             id_valid_i,
  input  logic [REG_W-1:0] id_rs1_i,
  input  logic [REG_W-1:0] id_rs2_i,
  input  logic             ex_valid_i,
  input  logic [MTR_W-1:0] ex_mtr_i,
  input  logic [REG_W-1:0] ex_rd_i,
  input  logic             mem_valid_i,
  input  logic             mem_reg_write_i,
  input  logic [REG_W-1:0] mem_rd_i,
`ifdef CTRL_PIPE_FWD_EN
  input  logic [REG_W-1:0] ex_rs1_i,
  input  logic [REG_W-1:0] ex_rs2_i,
  input  logic             wb_valid_i,
  input  logic             wb_reg_write_i,
  input  logic [REG_W-1:0] wb_rd_i,
`else
  input  logic             ex_reg_write_i,
`endif
  output logic             stall_o,
  output logic [FWD_W-1:0] forward_a_o,
  output logic [FWD_W-1:0] forward_b_o
);

  logic id_reads_ex;
  logic load_use;

  assign id_reads_ex = (ex_rd_i != '0) & ((ex_rd_i == id_rs1_i) | (ex_rd_i == id_rs2_i));
  assign load_use    = ex_valid_i & (ex_mtr_i == MEM_TO_REG_MEM) & id_valid_i & id_reads_ex;

`ifdef CTRL_PIPE_FWD_EN
  function automatic logic [FWD_W-1:0] fwd_sel(
    input logic [REG_W-1:0] rs,
    input logic             m_hit_en,
    input logic [REG_W-1:0] m_rd,
    input logic             w_hit_en,
    input logic [REG_W-1:0] w_rd
  );
    if (m_hit_en && m_rd != '0 && m_rd == rs) return FWD_MEM;
    if (w_hit_en && w_rd != '0 && w_rd == rs) return FWD_WB;
    return FWD_RF;
  endfunction

  assign forward_a_o = fwd_sel(ex_rs1_i, mem_valid_i & mem_reg_write_i, mem_rd_i,
                               wb_valid_i & wb_reg_write_i, wb_rd_i);
  assign forward_b_o = fwd_sel(ex_rs2_i, mem_valid_i & mem_reg_write_i, mem_rd_i,
                               wb_valid_i & wb_reg_write_i, wb_rd_i);
  assign stall_o     = load_use & ~redirect_i & ~hold_i;
`else
  logic raw_ex;
  logic raw_mem;

  // Without forwarding the consumer waits until its producer reaches WB.
  assign raw_ex  = ex_valid_i & ex_reg_write_i & id_reads_ex;
  assign raw_mem = mem_valid_i & mem_reg_write_i & (mem_rd_i != '0) &
                   ((mem_rd_i == id_rs1_i) | (mem_rd_i == id_rs2_i));

  assign forward_a_o = FWD_RF;
  assign forward_b_o = FWD_RF;
  assign stall_o     = (load_use | (id_valid_i & (raw_ex | raw_mem))) & ~redirect_i & ~hold_i;
`endif

endmodule

// File: rtl/ctrl_pipe.sv
// rtl/ctrl_pipe.sv - ID/EX, EX/MEM, MEM/WB control registers, branch resolve, stall/flush
// CTRL_PIPE_FWD_EN enables operand forwarding in hazard_unit.
module ctrl_pipe
  import ctrl_pipe_pkg::*;
(
  input logic        clk,
  input logic        rstn,
  ctrl_pipe_if.slave bus
);

  idex_t  idex_q,  idex_d;
  exmem_t exmem_q, exmem_d;
  memwb_t memwb_q, memwb_d;

  logic taken;
  logic redirect;
  logic flush;
  logic stall;

  assign taken    = idex_q.m[M_BRANCH] & (idex_q.m[M_B_TYPE] ? bus.ex_zero : ~bus.ex_zero);
  assign redirect = idex_q.valid & (taken | (mtr_of(idex_q.wb) == MEM_TO_REG_PC4));
  assign flush    = redirect & ~bus.hold;

  always_comb begin
    idex_d  = idex_q;
    exmem_d = exmem_q;
    memwb_d = memwb_q;
    if (!bus.hold) begin
      exmem_d.valid     = idex_q.valid;
      exmem_d.mem_write = idex_q.m[M_MEM_WRITE];
      exmem_d.wb        = idex_q.wb;
      exmem_d.rd        = idex_q.rd;
      memwb_d.valid     = exmem_q.valid;
      memwb_d.wb        = exmem_q.wb;
      memwb_d.rd        = exmem_q.rd;
      if (flush || stall || !bus.id_valid) begin
        idex_d = '0;
      end else begin
        idex_d.valid = 1'b1;
        idex_d.ex    = bus.id_ex;
        idex_d.m     = bus.id_m;
        idex_d.wb    = bus.id_wb;
        idex_d.rd    = bus.id_rd;
`ifdef CTRL_PIPE_FWD_EN
        idex_d.rs1   = bus.id_rs1;
        idex_d.rs2   = bus.id_rs2;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
    end
  end

  hazard_unit u_hazard (
    .hold_i          (bus.hold),
    .redirect_i      (redirect),
    .id_valid_i      (bus.id_valid),
    .id_rs1_i        (bus.id_rs1),
    .id_rs2_i        (bus.id_rs2),
    .ex_valid_i      (idex_q.valid),
    .ex_mtr_i        (mtr_of(idex_q.wb)),
    .ex_rd_i         (idex_q.rd),
    .mem_valid_i     (exmem_q.valid),
    .mem_reg_write_i (exmem_q.wb[WB_REG_WRITE]),
    .mem_rd_i        (exmem_q.rd),
`ifdef CTRL_PIPE_FWD_EN
    .ex_rs1_i        (idex_q.rs1),
    .ex_rs2_i        (idex_q.rs2),
    .wb_valid_i      (memwb_q.valid),
    .wb_reg_write_i  (memwb_q.wb[WB_REG_WRITE]),
    .wb_rd_i         (memwb_q.rd),
`else
    .ex_reg_write_i  (idex_q.wb[WB_REG_WRITE]),
`endif
    .stall_o         (stall),
    .forward_a_o     (bus.forward_a),
    .forward_b_o     (bus.forward_b)
  );

  assign bus.stall         = stall;
  assign bus.flush         = flush;
  assign bus.ex_valid      = idex_q.valid;
  assign bus.ex_ctrl       = idex_q.valid ? idex_q.ex : '0;
  assign bus.mem_write     = exmem_q.valid & exmem_q.mem_write;
  assign bus.mem_to_reg_m  = exmem_q.valid ? mtr_of(exmem_q.wb) : '0;
  assign bus.mem_rd        = exmem_q.valid ? exmem_q.rd : '0;
  assign bus.wb_reg_write  = memwb_q.valid & memwb_q.wb[WB_REG_WRITE];
  assign bus.wb_mem_to_reg = memwb_q.valid ? mtr_of(memwb_q.wb) : '0;
  assign bus.wb_rd         = memwb_q.valid ? memwb_q.rd : '0;

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb/tb_ctrl_pipe.sv - directed checks of ctrl_pipe; expectations follow CTRL_PIPE_FWD_EN
module tb_ctrl_pipe;
  import ctrl_pipe_pkg::*;

`ifdef CTRL_PIPE_FWD_EN
  localparam bit FWD_ON = 1'b1;
`else
  localparam bit FWD_ON = 1'b0;
`endif

  logic clk;
  logic rstn;
  int   checks;
  int   errors;

  ctrl_pipe_if bus ();

  ctrl_pipe dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] ex, input logic [2:0] m,
                        input logic [2:0] wb, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2);
    bus.id_valid = v;
    bus.id_ex    = ex;
    bus.id_m     = m;
    bus.id_wb    = wb;
    bus.id_rd    = rd;
    bus.id_rs1   = rs1;
    bus.id_rs2   = rs2;
    #1;
  endtask

  task automatic drain();
    set_id(1'b0, 5'h00, 3'b000, 3'b000, 5'd0, 5'd0, 5'd0);
    for (int i = 0; i < 3; i++) step();
  endtask

  task automatic count_stalls(input string tag, input int exp);
    int n;
    n = 0;
    while (bus.stall && n < 6) begin
      n++;
      step();
    end
    check_eq(tag, 8'(n), 8'(exp));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rstn = 1'b0;
    bus.hold = 1'b0;
    bus.ex_zero = 1'b0;
    set_id(1'b0, 5'h00, 3'b000, 3'b000, 5'd0, 5'd0, 5'd0);
    #12;
    check_eq("rst_ex_valid", 8'(bus.ex_valid), 8'h0);
    check_eq("rst_ex_ctrl", 8'(bus.ex_ctrl), 8'h0);
    check_eq("rst_wb_reg_write", 8'(bus.wb_reg_write), 8'h0);
    check_eq("rst_stall", 8'(bus.stall), 8'h0);
    check_eq("rst_flush", 8'(bus.flush), 8'h0);
    check_eq("rst_fwd_a", 8'(bus.forward_a), 8'h0);
    step();
    rstn = 1'b1;

    // load-use: lw x5 then add x6,x5,x7
    set_id(1'b1, 5'h10, 3'b000, 3'b111, 5'd5, 5'd1, 5'd0);
    check_eq("lu_pre_stall", 8'(bus.stall), 8'h0);
    step();
    set_id(1'b1, 5'h02, 3'b000, 3'b100, 5'd6, 5'd5, 5'd7);
    check_eq("lu_ex_valid", 8'(bus.ex_valid), 8'h1);
    check_eq("lu_ex_ctrl", 8'(bus.ex_ctrl), 8'h10);
    check_eq("lu_stall", 8'(bus.stall), 8'h1);
    step();
    check_eq("lu_bubble", 8'(bus.ex_valid), 8'h0);
    check_eq("lu_mem_rd", 8'(bus.mem_rd), 8'h05);
    check_eq("lu_mem_mtr", 8'(bus.mem_to_reg_m), 8'h3);
    count_stalls("lu_extra_stalls", FWD_ON ? 0 : 1);
    step();
    check_eq("lu_add_in_ex", 8'(bus.ex_ctrl), 8'h02);
    check_eq("lu_fwd_a", 8'(bus.forward_a), FWD_ON ? 8'h2 : 8'h0);
    check_eq("lu_fwd_b", 8'(bus.forward_b), 8'h0);
    drain();

    // forwarding priority: addi x3, addi x3, add x4,x3,x3
    set_id(1'b1, 5'h10, 3'b000, 3'b101, 5'd3, 5'd0, 5'd0);
    step();
    set_id(1'b1, 5'h10, 3'b000, 3'b101, 5'd3, 5'd0, 5'd0);
    check_eq("fp_no_stall_x0", 8'(bus.stall), 8'h0);
    step();
    set_id(1'b1, 5'h02, 3'b000, 3'b100, 5'd4, 5'd3, 5'd3);
    check_eq("fp_mem_mtr", 8'(bus.mem_to_reg_m), 8'h1);
    check_eq("fp_mem_rd", 8'(bus.mem_rd), 8'h03);
    count_stalls("fp_stalls", FWD_ON ? 0 : 2);
    step();
    check_eq("fp_ex_valid", 8'(bus.ex_valid), 8'h1);
    check_eq("fp_fwd_a", 8'(bus.forward_a), FWD_ON ? 8'h1 : 8'h0);
    check_eq("fp_fwd_b", 8'(bus.forward_b), FWD_ON ? 8'h1 : 8'h0);
    check_eq("fp_wb_reg_write", 8'(bus.wb_reg_write), FWD_ON ? 8'h1 : 8'h0);
    drain();

    // beq taken, bne not taken, store enable, bne taken
    set_id(1'b1, 5'h06, 3'b110, 3'b000, 5'd0, 5'd0, 5'd0);
    step();
    bus.ex_zero = 1'b1;
    set_id(1'b1, 5'h10, 3'b000, 3'b101, 5'd9, 5'd0, 5'd0);
    check_eq("beq_flush", 8'(bus.flush), 8'h1);
    check_eq("beq_stall", 8'(bus.stall), 8'h0);
    step();
    check_eq("beq_killed", 8'(bus.ex_valid), 8'h0);
    check_eq("beq_mem_write", 8'(bus.mem_write), 8'h0);
    check_eq("beq_flush_off", 8'(bus.flush), 8'h0);
    set_id(1'b1, 5'h06, 3'b100, 3'b000, 5'd0, 5'd0, 5'd0);
    step();
    set_id(1'b1, 5'h10, 3'b000, 3'b101, 5'd9, 5'd0, 5'd0);
    check_eq("bne_nt_flush", 8'(bus.flush), 8'h0);
    step();
    check_eq("bne_nt_next", 8'(bus.ex_valid), 8'h1);
    set_id(1'b1, 5'h10, 3'b001, 3'b000, 5'd0, 5'd2, 5'd8);
    step();
    set_id(1'b0, 5'h00, 3'b000, 3'b000, 5'd0, 5'd0, 5'd0);
    step();
    check_eq("sw_mem_write", 8'(bus.mem_write), 8'h1);
    set_id(1'b1, 5'h06, 3'b100, 3'b000, 5'd0, 5'd0, 5'd0);
    step();
    bus.ex_zero = 1'b0;
    set_id(1'b0, 5'h00, 3'b000, 3'b000, 5'd0, 5'd0, 5'd0);
    check_eq("bne_t_flush", 8'(bus.flush), 8'h1);
    drain();

    // jal held for three cycles
    set_id(1'b1, 5'h00, 3'b000, 3'b110, 5'd1, 5'd0, 5'd0);
    step();
    bus.hold = 1'b1;
    set_id(1'b1, 5'h10, 3'b000, 3'b101, 5'd9, 5'd0, 5'd0);
    for (int i = 0; i < 3; i++) begin
      check_eq("hold_flush", 8'(bus.flush), 8'h0);
      check_eq("hold_ex_kept", 8'(bus.ex_valid), 8'h1);
      check_eq("hold_mem_frozen", 8'(bus.mem_rd), 8'h00);
      step();
    end
    bus.hold = 1'b0;
    #1;
    check_eq("jal_flush", 8'(bus.flush), 8'h1);
    step();
    check_eq("jal_flush_once", 8'(bus.flush), 8'h0);
    check_eq("jal_killed", 8'(bus.ex_valid), 8'h0);
    check_eq("jal_mem_mtr", 8'(bus.mem_to_reg_m), 8'h2);
    check_eq("jal_mem_rd", 8'(bus.mem_rd), 8'h01);
    drain();

    // redirect and load-use together
    set_id(1'b1, 5'h10, 3'b110, 3'b111, 5'd5, 5'd0, 5'd0);
    step();
    bus.ex_zero = 1'b1;
    set_id(1'b1, 5'h02, 3'b000, 3'b100, 5'd6, 5'd5, 5'd0);
    check_eq("fbs_flush", 8'(bus.flush), 8'h1);
    check_eq("fbs_stall", 8'(bus.stall), 8'h0);
    bus.hold = 1'b1;
    #1;
    check_eq("fbs_hold_stall", 8'(bus.stall), 8'h0);
    check_eq("fbs_hold_flush", 8'(bus.flush), 8'h0);
    bus.hold = 1'b0;
    bus.ex_zero = 1'b0;
    #1;
    check_eq("lu_only_stall", 8'(bus.stall), 8'h1);
    check_eq("lu_only_flush", 8'(bus.flush), 8'h0);
    drain();

    // x0 producer/consumer, then asynchronous reset mid-stream
    set_id(1'b1, 5'h10, 3'b000, 3'b111, 5'd0, 5'd1, 5'd0);
    step();
    set_id(1'b1, 5'h02, 3'b000, 3'b100, 5'd7, 5'd0, 5'd0);
    check_eq("x0_stall", 8'(bus.stall), 8'h0);
    step();
    check_eq("x0_fwd_a", 8'(bus.forward_a), 8'h0);
    check_eq("x0_fwd_b", 8'(bus.forward_b), 8'h0);
    set_id(1'b1, 5'h10, 3'b000, 3'b101, 5'd9, 5'd0, 5'd0);
    step();
    check_eq("pre_rst_ex_valid", 8'(bus.ex_valid), 8'h1);
    check_eq("pre_rst_wb_we", 8'(bus.wb_reg_write), 8'h1);
    check_eq("pre_rst_mem_rd", 8'(bus.mem_rd), 8'h07);
    #2;
    rstn = 1'b0;
    #1;
    check_eq("arst_ex_valid", 8'(bus.ex_valid), 8'h0);
    check_eq("arst_ex_ctrl", 8'(bus.ex_ctrl), 8'h0);
    check_eq("arst_wb_we", 8'(bus.wb_reg_write), 8'h0);
    check_eq("arst_mem_rd", 8'(bus.mem_rd), 8'h00);
    check_eq("arst_stall", 8'(bus.stall), 8'h0);
    check_eq("arst_flush", 8'(bus.flush), 8'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe.md
# ctrl_pipe

Carries decoded control bundles (`id_ex`, `id_m`, `id_wb`) from decode through the EX, MEM and WB pipeline registers of the 5-stage scpu core. Resolves taken branches and jumps in EX. Detects load-use and RAW hazards, drives stall/flush to fetch/decode, and produces the operand-forwarding selects for the ALU. It is the downstream consumer of the decode control encoding and owns every control pipeline register after ID.

## Interface
- No parameters; all widths are fixed by `ctrl_pipe_pkg`.
- `clk` in 1: core clock; all flops capture on its rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `hold` in 1: global freeze, for example a memory wait.
- `id_valid` in 1: the ID stage holds a real instruction.
- `id_ex` in 5: `{alu_src_b, alu_op[3:0]}`.
- `id_m` in 3: `{branch, b_type, mem_write}`; `b_type`=1 means beq, 0 means bne.
- `id_wb` in 3: `{reg_write, mem_to_reg[1:0]}`; encodings are 00 ALU, 01 IMM, 10 PC+4 (jump), 11 MEM (load).
- `id_rd`, `id_rs1`, `id_rs2` in 5 each: register indices of the ID instruction.
- `ex_zero` in 1: ALU zero flag for the instruction currently in EX.
- `ex_ctrl` out 5: EX-stage `{alu_src_b, alu_op}`.
- `ex_valid` out 1: EX stage holds a real instruction.
- `mem_write` out 1: valid-gated store enable in MEM.
- `mem_to_reg_m` out 2: `mem_to_reg` of the MEM-stage instruction.
- `mem_rd` out 5: destination register in MEM.
- `wb_reg_write` out 1: valid-gated register-file write enable.
- `wb_mem_to_reg` out 2: write-back source select.
- `wb_rd` out 5: destination register in WB.
- `stall` out 1: hold PC and the IF/ID register.
- `flush` out 1: kill IF/ID and redirect the PC.
- `forward_a`, `forward_b` out 2 each: 00 register file, 01 EX/MEM result, 10 MEM/WB result.

## Operation
- There are three register stages: ID/EX, EX/MEM and MEM/WB.
  - Each stage holds valid, ex/m/wb fields and rd.
  - ID/EX additionally holds rs1 and rs2.
- Stage outputs are gated by that stage's valid: invalid means all enables read as 0.
- `redirect` = ex_valid & (
  - (branch & (b_type ? ex_zero : ~ex_zero)), or
  - ex `mem_to_reg`==10).
- `flush` = redirect & ~hold.
- Load-use condition: ex_valid & ex `mem_to_reg`==11 & id_valid & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2).
  - Both rs fields are always compared.
  - Spurious stalls on instructions that do not read rs2 are accepted.
- `stall` = load_use & ~redirect & ~hold. Flush beats stall.
- ID/EX next value, in priority order:
  - hold: keep current contents.
  - flush or stall or ~id_valid: bubble (valid=0).
  - otherwise: capture the id_* inputs.
- EX/MEM and MEM/WB shift every cycle unless `hold` is asserted.
- Forwarding, computed for rs1 (forward_a) and rs2 (forward_b) of ID/EX:
  - 01 if mem_valid & mem reg_write & mem_rd!=0 & mem_rd==rs.
  - else 10 if wb_valid & wb reg_write & wb_rd!=0 & wb_rd==rs.
  - else 00.
  - MEM takes priority over WB.
- The register file is write-through, so no WB→ID hazard handling is needed.

## Timing
- Reset values: all stage valids 0 and all outputs 0, including `stall`, `flush` and `forward_*`.
- Reset asserted mid-operation clears in-flight instructions immediately; no drain.
- Control reaches EX, MEM and WB 1, 2 and 3 cycles after ID capture.
- `stall`, `flush` and `forward_*` are combinational from the current stage registers; there are no registered outputs.
- Branch penalty is 2 cycles: the IF and ID instructions are killed.
- A load-use stall lasts exactly 1 cycle; the bubble then separates the load from its consumer and the operand forwards from WB.
- If `hold` rises while `redirect` is pending, `flush` deasserts; it reasserts on the first non-hold cycle.

## Configuration
- `CTRL_PIPE_FWD_EN` defined: the forwarding described above is implemented.
- Undefined:
  - `forward_a` and `forward_b` are tied to 00.
  - `stall` also asserts whenever a nonzero id_rs1 or id_rs2 matches ex_rd (with ex reg_write) or mem_rd (with mem reg_write), valid-qualified.
  - Flush priority and hold gating are unchanged.

## Structure
- `ctrl_pipe_pkg` holds:
  - field widths;
  - `MEM_TO_REG_ALU`, `_IMM`, `_PC4`, `_MEM`;
  - `FWD_RF`, `FWD_MEM`, `FWD_WB`;
  - bit-position constants for the ex/m/wb bundles.
- Sub-module `hazard_unit` (combinational) computes load-use, `stall` and `forward_*`. The stage registers stay in `ctrl_pipe`.

## Test plan
- Load-use:
  - Stimulus: lw x5 (wb=1_11, rd=5) followed by add with rs1=5.
  - Response: `stall`=1 for one cycle and ex_valid=0 the next cycle; the add then reaches EX with forward_a=10.
- Forwarding priority:
  - Stimulus: addi x3, addi x3, then add x4,x3,x3 back-to-back.
  - Response: forward_a=forward_b=01 (MEM wins over WB).
- beq taken and bne not-taken:
  - Stimulus: beq (m=110) in EX with ex_zero=1; then bne (m=100) with ex_zero=1.
  - Response: `flush`=1, and the next cycle ex_valid=0 with mem_write=0; for the bne, `flush`=0.
- Jump, hold and flush-beats-stall:
  - Stimulus: jal (wb=1_10) in EX with hold=1 for 3 cycles, then hold=0; separately, redirect and load_use asserted in the same cycle.
  - Response: `flush`=0 while held, then 1 for one cycle; in the simultaneous case `flush`=1 and `stall`=0.
- x0 and reset:
  - Stimulus: a writer with rd=0 followed by a reader with rs1=0; then rstn low mid-stream.
  - Response: no forward and no stall for rd=0; on reset, all outputs are 0 asynchronously.
- Build with `CTRL_PIPE_FWD_EN` undefined:
  - Stimulus: addi x3 followed by add with rs1=3.
  - Response: `stall`=1 for 2 cycles, `forward_a`=00.
